// File: rtl/piso_tx_pkg.sv
// piso_tx_pkg: shared types and constants for the piso_tx serial transmitter.
//   state_t           - FSM states (IDLE, SHIFT, PARITY)
//   tx_out_t          - registered serial-side outputs
//   PISO_TX_MAX_WIDTH - upper bound on the WIDTH parameter
package piso_tx_pkg;

  localparam int PISO_TX_MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  typedef struct packed {
    logic sdo;
    logic sframe;
    logic done;
  } tx_out_t;

endpackage

// File: rtl/piso_tx.sv
// piso_tx: parallel-in/serial-out transmitter with a valid/ready load.
// A WIDTH-bit word is shifted out MSB-first on sdo while sframe is high.
// done pulses for one cycle in the first idle cycle after each frame.
//
// Optional feature: define PISO_TX_PARITY_EN to append an even-parity bit
// after the data bits (frame = WIDTH+1 bits). Ports are the same either way.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   din    - parallel word, sampled only when load && ready
//   load   - load request
//   ready  - idle, a load is accepted this cycle
//   sdo    - serial data (registered)
//   sframe - high while sdo carries a frame bit (registered)
//   done   - one-cycle end-of-frame pulse (registered)
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             sdo,
  output logic             sframe,
  output logic             done
);

`ifdef PISO_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME = WIDTH + PAR_BITS;
  localparam int CW    = $clog2(WIDTH + 1);

  if (WIDTH < 2 || WIDTH > PISO_TX_MAX_WIDTH) begin : g_width_chk
    $error("piso_tx: WIDTH must be in 2..32");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  tx_out_t          out_q, out_d;
`ifdef PISO_TX_PARITY_EN
  // Running XOR of the bits already shifted out of the captured word.
  logic             par_q, par_d;
`endif

  assign ready  = (state_q == IDLE);
  assign sdo    = out_q.sdo;
  assign sframe = out_q.sframe;
  assign done   = out_q.done;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    out_d   = '0;
`ifdef PISO_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (load && ready) begin
          state_d = SHIFT;
          sreg_d  = din;
          cnt_d   = CW'(FRAME - 1);
`ifdef PISO_TX_PARITY_EN
          par_d   = 1'b0;
`endif
        end
      end
      SHIFT: begin
        sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q - 1'b1;
`ifdef PISO_TX_PARITY_EN
        par_d  = par_q ^ sreg_q[WIDTH-1];
`endif
        // The counter also spans the parity slot, so the last data bit
        // is reached at count PAR_BITS rather than 0.
        if (cnt_q == CW'(PAR_BITS)) begin
`ifdef PISO_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef PISO_TX_PARITY_EN
      PARITY: begin
        state_d = IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered: compute what the next cycle presents.
    out_d.sframe = (state_d != IDLE);
    out_d.done   = (state_q != IDLE) && (state_d == IDLE);
    if (state_d == SHIFT) out_d.sdo = sreg_d[WIDTH-1];
`ifdef PISO_TX_PARITY_EN
    if (state_d == PARITY) out_d.sdo = par_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
`ifdef PISO_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
`ifdef PISO_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed scenarios plus random load/reset traffic for piso_tx
// (WIDTH=8). A per-cycle expectation queue is filled from each accepted word
// and compared against the DUT on every falling edge; captured frames are
// also checked against hand-computed words.
module tb_piso_tx;
  localparam int W = 8;
`ifdef PISO_TX_PARITY_EN
  localparam int F = W + 1;
`else
  localparam int F = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         load = 1'b0;
  logic         ready, sdo, sframe, done;

  piso_tx #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .din(din), .load(load),
    .ready(ready), .sdo(sdo), .sframe(sframe), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic sdo;
    logic sframe;
    logic done;
    logic ready;
  } exp_t;

  localparam exp_t IDLE_E = '{sdo: 1'b0, sframe: 1'b0, done: 1'b0, ready: 1'b1};

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t cur = IDLE_E;
  exp_t q[$];
  bit   armed = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an accepted word becomes F frame cycles (MSB first, parity
  // last when enabled) followed by one done cycle; anything else is idle.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      cur   = IDLE_E;
      armed = 1'b1;
    end else begin
      if (load && cur.ready) begin
        for (int k = W - 1; k >= 0; k--)
          q.push_back('{sdo: din[k], sframe: 1'b1, done: 1'b0, ready: 1'b0});
        if (F > W)
          q.push_back('{sdo: ^din, sframe: 1'b1, done: 1'b0, ready: 1'b0});
        q.push_back('{sdo: 1'b0, sframe: 1'b0, done: 1'b1, ready: 1'b1});
      end
      cur = (q.size() > 0) ? q.pop_front() : IDLE_E;
    end
  end

  // Frame monitor: collects sdo while sframe is high, latches it on done.
  logic [F-1:0] bits = '0;
  logic [F-1:0] last_frame = '0;
  int           nbits = 0;
  int           last_nbits = 0;
  int           nfr = 0;

  always @(negedge clk) begin
    if (armed) begin
      chk("sdo",    {31'd0, sdo},    {31'd0, cur.sdo});
      chk("sframe", {31'd0, sframe}, {31'd0, cur.sframe});
      chk("done",   {31'd0, done},   {31'd0, cur.done});
      chk("ready",  {31'd0, ready},  {31'd0, cur.ready});
      if (done === 1'b1) begin
        last_frame = bits;
        last_nbits = nbits;
        nfr++;
      end
      if (sframe === 1'b1) begin
        bits = {bits[F-2:0], sdo};
        nbits++;
      end else begin
        bits  = '0;
        nbits = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for the falling edge of a done cycle.
  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 3 * F; i++) begin
      @(negedge clk);
      #1;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_timeout"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic send(input logic [W-1:0] w);
    @(posedge clk); #1;
    load = 1'b1;
    din  = w;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  int nfr0;
  logic [F-1:0] exp_a5, exp_07, exp_f0, exp_81, exp_7e, f1;

  initial begin
`ifdef PISO_TX_PARITY_EN
    exp_a5 = 9'h14A; exp_07 = 9'h00F; exp_f0 = 9'h1E0;
    exp_81 = 9'h102; exp_7e = 9'h0FC;
`else
    exp_a5 = 8'hA5;  exp_07 = 8'h07;  exp_f0 = 8'hF0;
    exp_81 = 8'h81;  exp_7e = 8'h7E;
`endif
    // Reset then idle.
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(4);
    chk("idle_nfr", nfr, 0);

    // Single frame.
    send(8'hA5);
    wait_done("a5");
    chk("a5_bits",  {23'd0, last_frame}, {23'd0, exp_a5});
    chk("a5_nbits", last_nbits, F);
    step(3);

    // Parity weight (odd popcount).
    send(8'h07);
    wait_done("07");
    chk("07_bits", {23'd0, last_frame}, {23'd0, exp_07});
    step(2);

    // Load while busy is ignored.
    nfr0 = nfr;
    @(posedge clk); #1;
    load = 1'b1; din = 8'hF0;
    @(posedge clk); #1;           // accept edge N
    load = 1'b0;
    step(2);
    load = 1'b1; din = 8'h0F;     // sampled at N+3
    step(1);
    load = 1'b0;
    wait_done("f0");
    chk("f0_bits", {23'd0, last_frame}, {23'd0, exp_f0});
    step(F + 4);
    chk("f0_nfr", nfr - nfr0, 1);

    // Back-to-back.
    nfr0 = nfr;
    load = 1'b1; din = 8'h81;
    wait_done("b2b1");
    f1  = last_frame;
    din = 8'h7E;
    wait_done("b2b2");
    load = 1'b0;
    chk("b2b_first",  {23'd0, f1}, {23'd0, exp_81});
    chk("b2b_second", {23'd0, last_frame}, {23'd0, exp_7e});
    step(F + 4);
    chk("b2b_nfr", nfr - nfr0, 2);

    // Reset mid-frame.
    nfr0 = nfr;
    @(posedge clk); #1;
    load = 1'b1; din = 8'hFF;
    @(posedge clk); #1;           // accept edge N
    load = 1'b0;
    step(3);
    rst = 1'b1;                   // sampled at N+4
    step(1);
    rst = 1'b0;
    chk("abort_sframe", {31'd0, sframe}, 32'd0);
    chk("abort_ready",  {31'd0, ready},  32'd1);
    step(F + 4);
    chk("abort_nfr", nfr - nfr0, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      load = ($urandom_range(0, 2) == 0);
      din  = W'($urandom);
      rst  = ($urandom_range(0, 99) == 0);
      step(1);
    end
    load = 1'b0;
    rst  = 1'b0;
    step(F + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
